spi_frame_master: RTL and testbench

//  Upstream master for the framed serial echo slave. Accepts a parallel byte on a

---
 rtl/spi_frame_master_if.sv | 38 +++
 rtl/spi_frame_master.sv | 214 +++++++++++++++++++++
 tb/tb_spi_frame_master.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_master_if.sv
// ----------------------------------------------------------------------------
// spi_frame_master_if
//   Bundle of the byte handshake, the serial link and the status pulses of
//   spi_frame_master.
//   master : view of spi_frame_master (drives tx_ready, serial outputs, status)
//   slave  : view of whoever drives the byte source and the miso line
//   Handshake: a byte moves on a rising clk edge where tx_valid && tx_ready;
//   tx_ready is high only while the master is idle, and tx_valid may be held
//   high across frames without a second byte being taken early.
//   dbg_state exposes the master FSM encoding for observation.
// ----------------------------------------------------------------------------
interface spi_frame_master_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       cs_n;
   logic       start_n;
   logic       mosi;
   logic       miso;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       rx_timeout;
   logic       busy;
   logic [2:0] dbg_state;

   modport master (
      input  tx_data, tx_valid, miso,
      output tx_ready, cs_n, start_n, mosi, rx_data, rx_valid, rx_err,
             rx_timeout, busy, dbg_state
   );

   modport slave (
      output tx_data, tx_valid, miso,
      input  tx_ready, cs_n, start_n, mosi, rx_data, rx_valid, rx_err,
             rx_timeout, busy, dbg_state
   );
endinterface

// File: rtl/spi_frame_master.sv
// ----------------------------------------------------------------------------
// spi_frame_master
//   Takes a byte on a valid/ready handshake, selects the slave, sends an
//   active-low start strobe for one bit period, shifts the byte out MSB-first
//   on mosi, then receives a reply frame (start 0, 8 bits MSB-first, stop 1)
//   on miso and presents it as a parallel byte with one-cycle status pulses.
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active-high
//   bus.tx_*   : byte handshake (tx_ready high only in IDLE)
//   bus.cs_n / start_n / mosi : serial outputs to the slave (registered)
//   bus.miso   : serial reply from the slave, idles high
//   bus.rx_data: last good reply byte; rx_valid / rx_err / rx_timeout pulses
//   bus.busy   : high in every state except IDLE
//   bus.dbg_state : current FSM state encoding
// ----------------------------------------------------------------------------
module spi_frame_master #(
   parameter int CLK_DIV = 4,   // clk cycles per bit period, >= 1
   parameter int TIMEOUT = 32   // bit periods to wait for the reply start bit, >= 1
) (
   input logic               clk,
   input logic               rst,
   spi_frame_master_if.master bus
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SELECT  = 3'd1,
      S_START   = 3'd2,
      S_SEND    = 3'd3,
      S_RX_WAIT = 3'd4,
      S_RX      = 3'd5,
      S_RX_STOP = 3'd6,
      S_DONE    = 3'd7
   } state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             rx_err_q, rx_err_d;
   logic             rx_timeout_q, rx_timeout_d;
   logic             cs_n_q, cs_n_d;
   logic             start_n_q, start_n_d;
   logic             mosi_q, mosi_d;
   logic             tick;

   // End of a bit period. With CLK_DIV == 1 the divider stays at 0 and every
   // cycle is a tick.
   assign tick = (div_q == DIV_LAST);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         cnt_q        <= '0;
         tmo_q        <= '0;
         shift_q      <= '0;
         rx_shift_q   <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_err_q     <= 1'b0;
         rx_timeout_q <= 1'b0;
         cs_n_q       <= 1'b1;
         start_n_q    <= 1'b1;
         mosi_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         cnt_q        <= cnt_d;
         tmo_q        <= tmo_d;
         shift_q      <= shift_d;
         rx_shift_q   <= rx_shift_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         rx_err_q     <= rx_err_d;
         rx_timeout_q <= rx_timeout_d;
         cs_n_q       <= cs_n_d;
         start_n_q    <= start_n_d;
         mosi_q       <= mosi_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      cnt_d        = cnt_q;
      tmo_d        = tmo_q;
      shift_d      = shift_q;
      rx_shift_d   = rx_shift_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      rx_err_d     = 1'b0;
      rx_timeout_d = 1'b0;

      // The divider only runs in the timed states; the wrap on tick is what
      // aligns each state to a whole bit period.
      if (state_q == S_IDLE || state_q == S_DONE || tick) begin
         div_d = '0;
      end else begin
         div_d = div_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.tx_valid) begin
               shift_d = bus.tx_data;
               state_d = S_SELECT;
            end
         end
         S_SELECT: begin
            if (tick) state_d = S_START;
         end
         S_START: begin
            if (tick) begin
               cnt_d   = 3'd7;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            // Leave on the tick that closes the cnt==0 period instead of
            // decrementing, so the counter never wraps.
            if (tick) begin
               if (cnt_q == 3'd0) begin
                  tmo_d   = '0;
                  state_d = S_RX_WAIT;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         S_RX_WAIT: begin
            if (tick) begin
               if (!bus.miso) begin
                  cnt_d   = 3'd7;
                  state_d = S_RX;
               end else if (tmo_q == TMO_LAST) begin
                  rx_timeout_d = 1'b1;
                  state_d      = S_DONE;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
         end
         S_RX: begin
            if (tick) begin
               rx_shift_d[cnt_q] = bus.miso;
               if (cnt_q == 3'd0) begin
                  state_d = S_RX_STOP;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         S_RX_STOP: begin
            if (tick) begin
               if (bus.miso) begin
                  rx_data_d  = rx_shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  rx_err_d = 1'b1;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic: decoded from the next state so the serial pins are
   // registered and line up with the state they belong to.
   // -------------------------------------------------------------------------
   always_comb begin
      cs_n_d    = (state_d == S_IDLE) || (state_d == S_DONE);
      start_n_d = (state_d != S_START);
      mosi_d    = 1'b1;
      if (state_d == S_SEND) begin
         mosi_d = shift_d[cnt_d];
      end
   end

   assign bus.tx_ready   = (state_q == S_IDLE);
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.cs_n       = cs_n_q;
   assign bus.start_n    = start_n_q;
   assign bus.mosi       = mosi_q;
   assign bus.rx_data    = rx_data_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.rx_err     = rx_err_q;
   assign bus.rx_timeout = rx_timeout_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// ----------------------------------------------------------------------------
// tb_spi_frame_master
//   Two instances: unit 0 at CLK_DIV=4, unit 1 at CLK_DIV=1, both TIMEOUT=32.
//   Each has a behavioural slave that captures the sent byte and answers with
//   a framed reply (loopback, fixed byte, bad stop bit, or silence).
//   Expected items are queued by the stimulus; a negedge monitor pops and
//   compares them whenever a status pulse appears.
//   Handshake: a byte moves on a rising clk edge where tx_valid && tx_ready.
// ----------------------------------------------------------------------------
module tb_spi_frame_master;

   localparam int DIV0 = 4;
   localparam int DIV1 = 1;
   localparam int TMO  = 32;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- DUTs
   spi_frame_master_if if0 ();
   spi_frame_master_if if1 ();

   spi_frame_master #(.CLK_DIV(DIV0), .TIMEOUT(TMO)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   spi_frame_master #(.CLK_DIV(DIV1), .TIMEOUT(TMO)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   logic [1:0] tx_valid_r = 2'b00;
   logic [7:0] tx_data_r [2];
   logic [1:0] ready_w, busy_w, cs_n_w, start_n_w, mosi_w, rxv_w, rxe_w, rxt_w;
   logic [7:0] rx_data_w [2];

   assign if0.tx_valid = tx_valid_r[0];
   assign if1.tx_valid = tx_valid_r[1];
   assign if0.tx_data  = tx_data_r[0];
   assign if1.tx_data  = tx_data_r[1];
   assign ready_w   = {if1.tx_ready,   if0.tx_ready};
   assign busy_w    = {if1.busy,       if0.busy};
   assign cs_n_w    = {if1.cs_n,       if0.cs_n};
   assign start_n_w = {if1.start_n,    if0.start_n};
   assign mosi_w    = {if1.mosi,       if0.mosi};
   assign rxv_w     = {if1.rx_valid,   if0.rx_valid};
   assign rxe_w     = {if1.rx_err,     if0.rx_err};
   assign rxt_w     = {if1.rx_timeout, if0.rx_timeout};
   assign rx_data_w[0] = if0.rx_data;
   assign rx_data_w[1] = if1.rx_data;

   // ---------------------------------------------------------------- scoreboard
   // item = {unit, kind, rx_data}; kind 1=valid, 2=err, 3=timeout
   logic [10:0] exp_q[$];
   logic [8:0]  mosi_exp_q[$];
   logic [8:0]  mosi_got_q[$];
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input bit ok, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int div_of(input int u);
      return (u == 0) ? DIV0 : DIV1;
   endfunction

   // ---------------------------------------------------------------- slave models
   logic       slv_silent [2];
   logic       slv_stop   [2];
   logic       slv_fix_en [2];
   logic [7:0] slv_fix    [2];

   for (genvar g = 0; g < 2; g++) begin : g_slv
      logic miso_l = 1'b1;
      initial begin
         int d;
         int t;
         logic [7:0] got;
         logic [7:0] rep;
         d = (g == 0) ? DIV0 : DIV1;
         forever begin
            @(negedge clk);
            if (!rst && !start_n_w[g]) begin
               // m counts negedges since the START state was entered
               got = 8'h00;
               rep = 8'hFF;
               for (int m = 1; m <= 19 * d; m++) begin
                  @(negedge clk);
                  if (m < 19 * d && (rst || cs_n_w[g])) break;
                  if (m % d == 0 && m <= 8 * d) got[8 - m / d] = mosi_w[g];
                  if (m == 8 * d) begin
                     mosi_got_q.push_back({1'(g), got});
                     rep = slv_fix_en[g] ? slv_fix[g] : got;
                  end
                  if (m % d == 0 && m >= 9 * d && !slv_silent[g]) begin
                     t = m / d - 9;
                     if (t == 0)      miso_l = 1'b0;
                     else if (t <= 8) miso_l = rep[8 - t];
                     else if (t == 9) miso_l = slv_stop[g];
                     else             miso_l = 1'b1;
                  end
               end
               miso_l = 1'b1;
            end
         end
      end
   end

   assign if0.miso = g_slv[0].miso_l;
   assign if1.miso = g_slv[1].miso_l;

   // ---------------------------------------------------------------- monitor
   int   cyc = 0;
   int   hs_cyc [2];
   int   sn_len [2];
   int   cs_hi  [2];
   int   frames [2];
   logic prev_cs [2];
   logic prev_pulse [2];

   initial begin
      for (int u = 0; u < 2; u++) begin
         hs_cyc[u] = 0; sn_len[u] = 0; cs_hi[u] = 0; frames[u] = 0;
         prev_cs[u] = 1'b1; prev_pulse[u] = 1'b0;
      end
   end

   always @(negedge clk) begin
      int np;
      int lat;
      int exp_lat;
      logic [1:0]  kind;
      logic [10:0] got_itm;
      logic [10:0] exp_itm;
      logic [8:0]  mg;
      cyc++;
      for (int u = 0; u < 2; u++) begin
         if (rst) begin
            sn_len[u] = 0; prev_cs[u] = 1'b1; prev_pulse[u] = 1'b0; cs_hi[u] = 1;
         end else begin
            chk(busy_w[u] == !ready_w[u], "busy_vs_ready", 32'(busy_w[u]), 32'(!ready_w[u]));
            if (tx_valid_r[u] && ready_w[u]) hs_cyc[u] = cyc;

            if (!start_n_w[u]) begin
               sn_len[u]++;
            end else if (sn_len[u] != 0) begin
               chk(sn_len[u] == div_of(u), "start_n_width", 32'(sn_len[u]), 32'(div_of(u)));
               sn_len[u] = 0;
            end

            if (prev_cs[u] && !cs_n_w[u]) begin
               frames[u]++;
               chk(cs_hi[u] >= 1, "cs_n_gap", 32'(cs_hi[u]), 32'd1);
            end
            if (cs_n_w[u]) cs_hi[u]++;
            else           cs_hi[u] = 0;
            prev_cs[u] = cs_n_w[u];

            np = int'(rxv_w[u]) + int'(rxe_w[u]) + int'(rxt_w[u]);
            if (np > 1) chk(1'b0, "pulse_exclusive", 32'(np), 32'd1);
            if (np != 0) begin
               chk(!prev_pulse[u], "pulse_one_cycle", 32'(prev_pulse[u]), 32'd0);
               kind    = rxv_w[u] ? 2'd1 : (rxe_w[u] ? 2'd2 : 2'd3);
               got_itm = {1'(u), kind, rx_data_w[u]};
               if (exp_q.size() == 0) begin
                  chk(1'b0, "unexpected_pulse", 32'(got_itm), 32'd0);
               end else begin
                  exp_itm = exp_q.pop_front();
                  chk(got_itm == exp_itm, "rx_item", 32'(got_itm), 32'(exp_itm));
               end
               lat     = cyc - hs_cyc[u];
               exp_lat = (kind == 2'd3) ? (10 + TMO) * div_of(u) + 1 : 20 * div_of(u) + 1;
               chk(lat == exp_lat, "latency", 32'(lat), 32'(exp_lat));
            end
            prev_pulse[u] = (np != 0);
         end
      end
      if (mosi_got_q.size() != 0) begin
         mg = mosi_got_q.pop_front();
         if (mosi_exp_q.size() == 0) begin
            chk(1'b0, "unexpected_frame", 32'(mg), 32'd0);
         end else begin
            exp_itm[8:0] = mosi_exp_q.pop_front();
            chk(mg == exp_itm[8:0], "mosi_byte", 32'(mg), 32'(exp_itm[8:0]));
         end
      end
   end

   // ---------------------------------------------------------------- driver tasks
   task automatic send(input int u, input logic [7:0] d);
      int n;
      tx_data_r[u]  = d;
      tx_valid_r[u] = 1'b1;
      n = 0;
      while (!ready_w[u] && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(n < 500, "tx_accept", 32'(n), 32'd500);
      @(negedge clk);
      tx_valid_r[u] = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mosi_exp_q.size() != 0 || busy_w != 2'b00) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(n < 3000, "wait_idle", 32'(n), 32'd3000);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input int u);
      chk(cs_n_w[u] == 1'b1, "rst_cs_n", 32'(cs_n_w[u]), 32'd1);
      chk(start_n_w[u] == 1'b1, "rst_start_n", 32'(start_n_w[u]), 32'd1);
      chk(mosi_w[u] == 1'b1, "rst_mosi", 32'(mosi_w[u]), 32'd1);
      chk(busy_w[u] == 1'b0, "rst_busy", 32'(busy_w[u]), 32'd0);
      chk(rx_data_w[u] == 8'h00, "rst_rx_data", 32'(rx_data_w[u]), 32'd0);
      chk({rxv_w[u], rxe_w[u], rxt_w[u]} == 3'b000, "rst_pulses",
          32'({rxv_w[u], rxe_w[u], rxt_w[u]}), 32'd0);
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int f0;
      int n;
      for (int u = 0; u < 2; u++) begin
         tx_data_r[u]  = 8'h00;
         slv_silent[u] = 1'b0;
         slv_stop[u]   = 1'b1;
         slv_fix_en[u] = 1'b0;
         slv_fix[u]    = 8'h00;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs(0);
      check_reset_outputs(1);
      rst = 1'b0;
      @(negedge clk);
      chk(ready_w == 2'b11, "ready_after_reset", 32'(ready_w), 32'd3);

      // Loopback of 0xA9: mosi 1,0,1,0,1,0,0,1 and rx_data 0xA9
      mosi_exp_q.push_back({1'b0, 8'hA9});
      exp_q.push_back({1'b0, 2'd1, 8'hA9});
      send(0, 8'hA9);
      wait_idle();
      chk(rx_data_w[0] == 8'hA9, "rx_data_A9", 32'(rx_data_w[0]), 32'hA9);

      // Silent slave: timeout after 32 RX_WAIT ticks, rx_data held
      slv_silent[0] = 1'b1;
      mosi_exp_q.push_back({1'b0, 8'h12});
      exp_q.push_back({1'b0, 2'd3, 8'hA9});
      send(0, 8'h12);
      wait_idle();
      slv_silent[0] = 1'b0;
      chk(rx_data_w[0] == 8'hA9, "rx_data_after_timeout", 32'(rx_data_w[0]), 32'hA9);
      chk(ready_w[0] == 1'b1, "idle_after_timeout", 32'(ready_w[0]), 32'd1);

      // Reply 0x3C with stop bit 0: rx_err, rx_data unchanged
      slv_stop[0] = 1'b0;
      mosi_exp_q.push_back({1'b0, 8'h3C});
      exp_q.push_back({1'b0, 2'd2, 8'hA9});
      send(0, 8'h3C);
      wait_idle();
      slv_stop[0] = 1'b1;
      chk(rx_data_w[0] == 8'hA9, "rx_data_after_err", 32'(rx_data_w[0]), 32'hA9);

      // tx_valid held high: 0x55 then 0xC3 (changed mid-frame) -> two frames
      f0 = frames[0];
      mosi_exp_q.push_back({1'b0, 8'h55});
      mosi_exp_q.push_back({1'b0, 8'hC3});
      exp_q.push_back({1'b0, 2'd1, 8'h55});
      exp_q.push_back({1'b0, 2'd1, 8'hC3});
      tx_data_r[0]  = 8'h55;
      tx_valid_r[0] = 1'b1;
      @(negedge clk);
      repeat (10) @(negedge clk);
      tx_data_r[0] = 8'hC3;
      n = 0;
      while (!ready_w[0] && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(n < 500, "second_accept", 32'(n), 32'd500);
      @(negedge clk);
      tx_valid_r[0] = 1'b0;
      wait_idle();
      chk(frames[0] - f0 == 2, "held_valid_frames", 32'(frames[0] - f0), 32'd2);
      chk(rx_data_w[0] == 8'hC3, "rx_data_C3", 32'(rx_data_w[0]), 32'hC3);

      // CLK_DIV=1: loopback 0x5A, then send 0xFF with fixed reply 0x00
      mosi_exp_q.push_back({1'b1, 8'h5A});
      exp_q.push_back({1'b1, 2'd1, 8'h5A});
      send(1, 8'h5A);
      wait_idle();
      slv_fix_en[1] = 1'b1;
      slv_fix[1]    = 8'h00;
      mosi_exp_q.push_back({1'b1, 8'hFF});
      exp_q.push_back({1'b1, 2'd1, 8'h00});
      send(1, 8'hFF);
      wait_idle();
      slv_fix_en[1] = 1'b0;
      chk(rx_data_w[1] == 8'h00, "rx_data_div1", 32'(rx_data_w[1]), 32'd0);

      // Reset in the middle of SEND, 15 cycles after the handshake
      tx_data_r[0]  = 8'h00;
      tx_valid_r[0] = 1'b1;
      @(negedge clk);
      tx_valid_r[0] = 1'b0;
      repeat (14) @(negedge clk);
      chk(cs_n_w[0] == 1'b0, "pre_rst_cs_n", 32'(cs_n_w[0]), 32'd0);
      chk(mosi_w[0] == 1'b0, "pre_rst_mosi", 32'(mosi_w[0]), 32'd0);
      #1 rst = 1'b1;
      #1;
      check_reset_outputs(0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk(ready_w[0] == 1'b1, "ready_after_mid_rst", 32'(ready_w[0]), 32'd1);
      chk(busy_w == 2'b00, "busy_after_mid_rst", 32'(busy_w), 32'd0);
      repeat (30 * DIV0) @(negedge clk);
      chk(busy_w[0] == 1'b0, "no_resume_after_rst", 32'(busy_w[0]), 32'd0);

      // A clean frame after the aborted one
      mosi_exp_q.push_back({1'b0, 8'h81});
      exp_q.push_back({1'b0, 2'd1, 8'h81});
      send(0, 8'h81);
      wait_idle();
      chk(rx_data_w[0] == 8'h81, "rx_data_81", 32'(rx_data_w[0]), 32'h81);

      chk(exp_q.size() == 0, "exp_q_empty", 32'(exp_q.size()), 32'd0);
      chk(mosi_exp_q.size() == 0, "mosi_q_empty", 32'(mosi_exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
